// File: rtl/parser_pkg.sv
// Shared definitions for the order-message parser front end: message type
// codes, default payload size and statistics counter width.
package parser_pkg;

    localparam logic [1:0] MSG_ADD    = 2'b00;
    localparam logic [1:0] MSG_CANCEL = 2'b01;
    localparam logic [1:0] MSG_EXEC   = 2'b10;
    localparam logic [1:0] MSG_RSVD   = 2'b11;

    localparam int PAYLOAD_LEN_DEFAULT = 4;
    localparam int CNT_W               = 16;

endpackage : parser_pkg

// File: rtl/parser_msg_arb_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// scanning upward from ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int SRC_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SRC_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [SRC_W-1:0] gnt_idx
);

    logic             found;
    logic [SRC_W:0]   cand;

    // Candidate index is ptr+i folded back into 0..N-1, so N need not be a power of two.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (SRC_W+1)'(i);
            if (cand >= (SRC_W+1)'(N)) begin
                cand = cand - (SRC_W+1)'(N);
            end
            if (en && !found && req[cand[SRC_W-1:0]]) begin
                found                 = 1'b1;
                gnt[cand[SRC_W-1:0]] = 1'b1;
                gnt_idx               = cand[SRC_W-1:0];
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/parser_msg_arb.sv
// Round-robin front end for the order-message parser: picks one feed handler
// per cycle, registers its message, drops reserved types and keeps statistics.
module parser_msg_arb
    import parser_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int PAYLOAD_LEN = PAYLOAD_LEN_DEFAULT,
    parameter int SRC_W       = $clog2(N_SRC)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_SRC-1:0]               src_valid,
    output logic [N_SRC-1:0]               src_ready,
    input  logic [2*N_SRC-1:0]             src_type,
    input  logic [N_SRC*PAYLOAD_LEN*8-1:0] src_payload,
    input  logic                           pause,
    output logic                           msg_valid,
    output logic [1:0]                     msg_type,
    output logic [PAYLOAD_LEN*8-1:0]       msg_payload,
    output logic [SRC_W-1:0]               msg_src,
    output logic [CNT_W-1:0]               fwd_cnt,
    output logic [CNT_W-1:0]               drop_cnt
);

    localparam int PL_W = PAYLOAD_LEN * 8;

    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              msg_valid_q, msg_valid_d;
    logic [1:0]        msg_type_q, msg_type_d;
    logic [PL_W-1:0]   msg_payload_q, msg_payload_d;
    logic [SRC_W-1:0]  msg_src_q, msg_src_d;
    logic [CNT_W-1:0]  fwd_cnt_q, fwd_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [N_SRC-1:0]  gnt;
    logic [SRC_W-1:0]  gnt_idx;
    logic              arb_en;
    logic              gnt_any;
    logic [1:0]        gnt_type;
    logic [PL_W-1:0]   gnt_payload;
    logic              gnt_rsvd;

    // Ready is forced low during reset so a handshake racing reset is never seen as accepted.
    assign arb_en = !pause && !rst;

    rr_arbiter #(
        .N     (N_SRC),
        .SRC_W (SRC_W)
    ) u_rr_arbiter (
        .req     (src_valid),
        .ptr     (rr_ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign src_ready   = gnt;
    assign gnt_any     = |gnt;
    assign gnt_type    = src_type[2*int'(gnt_idx) +: 2];
    assign gnt_payload = src_payload[int'(gnt_idx)*PL_W +: PL_W];
    assign gnt_rsvd    = (gnt_type == MSG_RSVD);

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        msg_valid_d   = 1'b0;
        msg_type_d    = msg_type_q;
        msg_payload_d = msg_payload_q;
        msg_src_d     = msg_src_q;
        fwd_cnt_d     = fwd_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == SRC_W'(N_SRC-1)) ? '0 : gnt_idx + 1'b1;
            // Reserved messages are consumed so the source never stalls, but never forwarded.
            if (gnt_rsvd) begin
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end else begin
                msg_valid_d   = 1'b1;
                msg_type_d    = gnt_type;
                msg_payload_d = gnt_payload;
                msg_src_d     = gnt_idx;
                fwd_cnt_d     = fwd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            msg_valid_q   <= 1'b0;
            msg_type_q    <= '0;
            msg_payload_q <= '0;
            msg_src_q     <= '0;
            fwd_cnt_q     <= '0;
            drop_cnt_q    <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            msg_valid_q   <= msg_valid_d;
            msg_type_q    <= msg_type_d;
            msg_payload_q <= msg_payload_d;
            msg_src_q     <= msg_src_d;
            fwd_cnt_q     <= fwd_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign msg_valid   = msg_valid_q;
    assign msg_type    = msg_type_q;
    assign msg_payload = msg_payload_q;
    assign msg_src     = msg_src_q;
    assign fwd_cnt     = fwd_cnt_q;
    assign drop_cnt    = drop_cnt_q;

endmodule : parser_msg_arb
